mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/core_bus_pkg.sv | 26 ++
 rtl/mem_arb_pick.sv | 40 ++++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bus_pkg.sv
// Shared types and defaults for the core memory bus arbiter.
package core_bus_pkg;

  typedef enum logic {
    IDLE,
    WAIT_RSP
  } arb_state_e;

  typedef enum logic {
    INST,
    LSU
  } owner_e;

  localparam int unsigned STARVE_LIMIT_DEF = 4;

  localparam int unsigned GNT_INST = 0;
  localparam int unsigned GNT_LSU  = 1;

  // Width of a counter that must hold 0..limit, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-port grant picker: fixed LSU priority with instruction-port promotion,
// or round-robin when ARB_ROUND_ROBIN_EN is defined.
module mem_arb_pick
  import core_bus_pkg::*;
#(
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic             inst_req_i,
  input  logic             lsu_req_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  input  owner_e           rr_last_i,
  output logic [1:0]       gnt_o
);

  logic inst_wins;

`ifdef ARB_ROUND_ROBIN_EN
  logic unused_starve;
  assign unused_starve = ^starve_cnt_i;
  assign inst_wins     = (rr_last_i == LSU);
`else
  logic unused_rr;
  assign unused_rr = (rr_last_i == LSU);
  assign inst_wins = (starve_cnt_i == CNT_W'(STARVE_LIMIT));
`endif

  always_comb begin
    gnt_o = '0;
    if (inst_req_i && lsu_req_i) begin
      if (inst_wins) gnt_o[GNT_INST] = 1'b1;
      else           gnt_o[GNT_LSU]  = 1'b1;
    end else if (inst_req_i) begin
      gnt_o[GNT_INST] = 1'b1;
    end else if (lsu_req_i) begin
      gnt_o[GNT_LSU] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and LSU requests onto one shared memory with one read in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is LSU priority with promotion.
module mem_arbiter
  import core_bus_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              inst_mem_en,
  input  logic [3:0]        inst_mem_wen,
  input  logic [ADDR_W-1:0] inst_mem_addr,
  input  logic [31:0]       inst_mem_wdata,
  output logic              inst_mem_gnt,
  output logic [31:0]       inst_mem_rdata,
  output logic              inst_mem_rvld,
  input  logic              lsu_mem_en,
  input  logic [3:0]        lsu_mem_wen,
  input  logic [ADDR_W-1:0] lsu_mem_addr,
  input  logic [31:0]       lsu_mem_wdata,
  output logic              lsu_mem_gnt,
  output logic [31:0]       lsu_mem_rdata,
  output logic              lsu_mem_rvld,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvld,
  output logic              arb_busy
);

  localparam int unsigned CNT_W = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  owner_e           rr_last_q, rr_last_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic       can_grant;
  logic       rsp_fire;
  logic [1:0] gnt;

  // RSTN gates grants so every output is quiet while reset is held.
  assign can_grant = RSTN && ((state_q == IDLE) || mem_rvld);
  assign rsp_fire  = (state_q == WAIT_RSP) && mem_rvld;
  assign arb_busy  = (state_q == WAIT_RSP);

  mem_arb_pick #(
    .CNT_W        (CNT_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .inst_req_i   (inst_mem_en && can_grant),
    .lsu_req_i    (lsu_mem_en && can_grant),
    .starve_cnt_i (starve_q),
    .rr_last_i    (rr_last_q),
    .gnt_o        (gnt)
  );

  always_comb begin
    inst_mem_gnt   = gnt[GNT_INST];
    lsu_mem_gnt    = gnt[GNT_LSU];
    mem_en         = 1'b0;
    mem_wen        = '0;
    mem_addr       = '0;
    mem_wdata      = '0;
    inst_mem_rvld  = 1'b0;
    inst_mem_rdata = '0;
    lsu_mem_rvld   = 1'b0;
    lsu_mem_rdata  = '0;
    if (gnt[GNT_LSU]) begin
      mem_en    = 1'b1;
      mem_wen   = lsu_mem_wen;
      mem_addr  = lsu_mem_addr;
      mem_wdata = lsu_mem_wdata;
    end else if (gnt[GNT_INST]) begin
      mem_en    = 1'b1;
      mem_wen   = inst_mem_wen;
      mem_addr  = inst_mem_addr;
      mem_wdata = inst_mem_wdata;
    end
    if (rsp_fire) begin
      if (owner_q == INST) begin
        inst_mem_rvld  = 1'b1;
        inst_mem_rdata = mem_rdata;
      end else begin
        lsu_mem_rvld  = 1'b1;
        lsu_mem_rdata = mem_rdata;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    starve_d  = starve_q;
    if (rsp_fire) state_d = IDLE;
    // A back-to-back grant in the response cycle overrides the return to IDLE.
    if (gnt != 2'b00) begin
      rr_last_d = gnt[GNT_LSU] ? LSU : INST;
      if (mem_wen == 4'b0000) begin
        state_d = WAIT_RSP;
        owner_d = gnt[GNT_LSU] ? LSU : INST;
      end else begin
        state_d = IDLE;
      end
    end
    if (!inst_mem_en || gnt[GNT_INST]) starve_d = '0;
    else if (starve_q != LIMIT_C)      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      owner_q   <= INST;
      rr_last_q <= LSU;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      starve_q  <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the arbitration test follows ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        inst_mem_en;
  logic [3:0]  inst_mem_wen;
  logic [31:0] inst_mem_addr;
  logic [31:0] inst_mem_wdata;
  logic        inst_mem_gnt;
  logic [31:0] inst_mem_rdata;
  logic        inst_mem_rvld;
  logic        lsu_mem_en;
  logic [3:0]  lsu_mem_wen;
  logic [31:0] lsu_mem_addr;
  logic [31:0] lsu_mem_wdata;
  logic        lsu_mem_gnt;
  logic [31:0] lsu_mem_rdata;
  logic        lsu_mem_rvld;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rvld;
  logic        arb_busy;

  int checks = 0;
  int errors = 0;

  logic [137:0] all_out;
  assign all_out = {inst_mem_gnt, inst_mem_rdata, inst_mem_rvld, lsu_mem_gnt, lsu_mem_rdata,
                    lsu_mem_rvld, mem_en, mem_wen, mem_addr, mem_wdata, arb_busy};

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .ADDR_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .CLK            (CLK),
    .RSTN           (RSTN),
    .inst_mem_en    (inst_mem_en),
    .inst_mem_wen   (inst_mem_wen),
    .inst_mem_addr  (inst_mem_addr),
    .inst_mem_wdata (inst_mem_wdata),
    .inst_mem_gnt   (inst_mem_gnt),
    .inst_mem_rdata (inst_mem_rdata),
    .inst_mem_rvld  (inst_mem_rvld),
    .lsu_mem_en     (lsu_mem_en),
    .lsu_mem_wen    (lsu_mem_wen),
    .lsu_mem_addr   (lsu_mem_addr),
    .lsu_mem_wdata  (lsu_mem_wdata),
    .lsu_mem_gnt    (lsu_mem_gnt),
    .lsu_mem_rdata  (lsu_mem_rdata),
    .lsu_mem_rvld   (lsu_mem_rvld),
    .mem_en         (mem_en),
    .mem_wen        (mem_wen),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_rvld       (mem_rvld),
    .arb_busy       (arb_busy)
  );

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    inst_mem_en = 0; inst_mem_wen = '0; inst_mem_addr = '0; inst_mem_wdata = '0;
    lsu_mem_en = 0;  lsu_mem_wen = '0;  lsu_mem_addr = '0;  lsu_mem_wdata = '0;
    mem_rdata = '0;  mem_rvld = 0;
  endtask

  task automatic test_reset;
    RSTN = 0;
    idle_inputs();
    inst_mem_en = 1; lsu_mem_en = 1; mem_rvld = 1; mem_rdata = 32'hFFFF_FFFF;
    #2;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs_zero: got %h expected 0", all_out);
    end
    next_cycle();
    #2;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_held_zero: got %h expected 0", all_out);
    end
    next_cycle();
    idle_inputs();
    RSTN = 1;
    #2;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL post_reset_idle: got %h expected 0", all_out);
    end
  endtask

  task automatic test_inst_read;
    next_cycle();
    inst_mem_en = 1; inst_mem_wen = 4'h0; inst_mem_addr = 32'h10;
    #2;
    checks++;
    if ({inst_mem_gnt, lsu_mem_gnt, mem_en, mem_wen, mem_addr} !== {1'b1, 1'b0, 1'b1, 4'h0, 32'h10}) begin
      errors++;
      $display("FAIL inst_read_grant: got gnt=%b/%b en=%b wen=%h addr=%h expected 1/0 1 0 00000010",
               inst_mem_gnt, lsu_mem_gnt, mem_en, mem_wen, mem_addr);
    end
    next_cycle();
    inst_mem_en = 0; mem_rvld = 1; mem_rdata = 32'hDEAD_BEEF;
    #2;
    checks++;
    if ({arb_busy, inst_mem_rvld, inst_mem_rdata, lsu_mem_rvld} !== {1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL inst_read_rsp: got busy=%b irvld=%b irdata=%h lrvld=%b expected 1 1 deadbeef 0",
               arb_busy, inst_mem_rvld, inst_mem_rdata, lsu_mem_rvld);
    end
    next_cycle();
    mem_rvld = 0;
    #2;
    checks++;
    if ({arb_busy, inst_mem_rvld} !== 2'b00) begin
      errors++; $display("FAIL inst_read_done: got busy=%b irvld=%b expected 0 0", arb_busy, inst_mem_rvld);
    end
  endtask

  task automatic test_lsu_write;
    next_cycle();
    lsu_mem_en = 1; lsu_mem_wen = 4'hF; lsu_mem_addr = 32'h20; lsu_mem_wdata = 32'h1234_5678;
    #2;
    checks++;
    if ({lsu_mem_gnt, inst_mem_gnt, mem_en, mem_wen, mem_addr, mem_wdata} !==
        {1'b1, 1'b0, 1'b1, 4'hF, 32'h20, 32'h1234_5678}) begin
      errors++;
      $display("FAIL lsu_write_grant: got gnt=%b/%b en=%b wen=%h addr=%h wdata=%h expected 1/0 1 f 00000020 12345678",
               lsu_mem_gnt, inst_mem_gnt, mem_en, mem_wen, mem_addr, mem_wdata);
    end
    next_cycle();
    lsu_mem_en = 0; lsu_mem_wen = '0;
    inst_mem_en = 1; inst_mem_wen = 4'h0; inst_mem_addr = 32'h30;
    #2;
    checks++;
    if ({arb_busy, inst_mem_rvld, lsu_mem_rvld, inst_mem_gnt, lsu_mem_gnt, mem_addr} !==
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h30}) begin
      errors++;
      $display("FAIL lsu_write_next: got busy=%b rvld=%b/%b gnt=%b/%b addr=%h expected 0 0/0 1/0 00000030",
               arb_busy, inst_mem_rvld, lsu_mem_rvld, inst_mem_gnt, lsu_mem_gnt, mem_addr);
    end
    next_cycle();
    inst_mem_en = 0; mem_rvld = 1; mem_rdata = 32'h0000_1111;
    #2;
    checks++;
    if ({inst_mem_rvld, inst_mem_rdata} !== {1'b1, 32'h0000_1111}) begin
      errors++;
      $display("FAIL lsu_write_follow_rsp: got irvld=%b irdata=%h expected 1 00001111", inst_mem_rvld, inst_mem_rdata);
    end
    next_cycle();
    idle_inputs();
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_round_robin;
    logic [1:0] exp_gnt [4];
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
    // Single instruction write leaves the LSU as the next round-robin winner.
    next_cycle();
    inst_mem_en = 1; inst_mem_wen = 4'h1; inst_mem_addr = 32'h70;
    #2;
    checks++;
    if (inst_mem_gnt !== 1'b1) begin
      errors++; $display("FAIL rr_prime: got inst_gnt=%b expected 1", inst_mem_gnt);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      inst_mem_en = 1; inst_mem_wen = 4'h3; inst_mem_addr = 32'h80;
      lsu_mem_en = 1;  lsu_mem_wen = 4'hC;  lsu_mem_addr = 32'h90;
      #2;
      checks++;
      if ({inst_mem_gnt, lsu_mem_gnt} !== exp_gnt[i]) begin
        errors++;
        $display("FAIL rr_grant_%0d: got inst/lsu=%b%b expected %b", i, inst_mem_gnt, lsu_mem_gnt, exp_gnt[i]);
      end
    end
    next_cycle();
    idle_inputs();
  endtask
`else
  task automatic test_fixed_priority;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      inst_mem_en = 1; inst_mem_wen = 4'h3; inst_mem_addr = 32'h80;
      lsu_mem_en = 1;  lsu_mem_wen = 4'hC;  lsu_mem_addr = 32'h90;
      #2;
      checks++;
      if (i < 4) begin
        if ({inst_mem_gnt, lsu_mem_gnt, mem_addr} !== {1'b0, 1'b1, 32'h90}) begin
          errors++;
          $display("FAIL fixed_lsu_grant_%0d: got inst/lsu=%b%b addr=%h expected 01 00000090",
                   i, inst_mem_gnt, lsu_mem_gnt, mem_addr);
        end
      end else begin
        if ({inst_mem_gnt, lsu_mem_gnt, mem_addr} !== {1'b1, 1'b0, 32'h80}) begin
          errors++;
          $display("FAIL fixed_promote: got inst/lsu=%b%b addr=%h expected 10 00000080",
                   inst_mem_gnt, lsu_mem_gnt, mem_addr);
        end
      end
    end
    next_cycle();
    inst_mem_en = 0;
    #2;
    checks++;
    if ({inst_mem_gnt, lsu_mem_gnt} !== 2'b01) begin
      errors++; $display("FAIL fixed_after_promote: got inst/lsu=%b%b expected 01", inst_mem_gnt, lsu_mem_gnt);
    end
    next_cycle();
    idle_inputs();
  endtask
`endif

  task automatic test_delayed_rsp;
    next_cycle();
    lsu_mem_en = 1; lsu_mem_wen = 4'h0; lsu_mem_addr = 32'h40;
    #2;
    checks++;
    if ({lsu_mem_gnt, mem_addr} !== {1'b1, 32'h40}) begin
      errors++; $display("FAIL delay_lsu_grant: got gnt=%b addr=%h expected 1 00000040", lsu_mem_gnt, mem_addr);
    end
    for (int i = 1; i < 5; i++) begin
      next_cycle();
      lsu_mem_en = 0;
      inst_mem_en = 1; inst_mem_wen = 4'h0; inst_mem_addr = 32'h50;
      #2;
      checks++;
      if ({inst_mem_gnt, lsu_mem_gnt, mem_en, arb_busy, inst_mem_rvld, lsu_mem_rvld} !== 6'b000100) begin
        errors++;
        $display("FAIL delay_wait_%0d: got gnt=%b%b en=%b busy=%b rvld=%b%b expected 00 0 1 00",
                 i, inst_mem_gnt, lsu_mem_gnt, mem_en, arb_busy, inst_mem_rvld, lsu_mem_rvld);
      end
    end
    next_cycle();
    mem_rvld = 1; mem_rdata = 32'hCAFE_F00D;
    #2;
    checks++;
    if ({lsu_mem_rvld, lsu_mem_rdata, inst_mem_rvld, inst_mem_gnt, mem_addr} !==
        {1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h50}) begin
      errors++;
      $display("FAIL delay_rsp_b2b: got lrvld=%b lrdata=%h irvld=%b igint=%b addr=%h expected 1 cafef00d 0 1 00000050",
               lsu_mem_rvld, lsu_mem_rdata, inst_mem_rvld, inst_mem_gnt, mem_addr);
    end
    next_cycle();
    inst_mem_en = 0; mem_rvld = 1; mem_rdata = 32'h0BAD_F00D;
    #2;
    checks++;
    if ({arb_busy, inst_mem_rvld, inst_mem_rdata, lsu_mem_rvld} !== {1'b1, 1'b1, 32'h0BAD_F00D, 1'b0}) begin
      errors++;
      $display("FAIL delay_second_rsp: got busy=%b irvld=%b irdata=%h lrvld=%b expected 1 1 0badf00d 0",
               arb_busy, inst_mem_rvld, inst_mem_rdata, lsu_mem_rvld);
    end
    next_cycle();
    idle_inputs();
    #2;
    checks++;
    if (arb_busy !== 1'b0) begin
      errors++; $display("FAIL delay_idle: got busy=%b expected 0", arb_busy);
    end
  endtask

  task automatic test_reset_in_wait;
    next_cycle();
    inst_mem_en = 1; inst_mem_wen = 4'h0; inst_mem_addr = 32'h60;
    #2;
    checks++;
    if (inst_mem_gnt !== 1'b1) begin
      errors++; $display("FAIL rstwait_grant: got gnt=%b expected 1", inst_mem_gnt);
    end
    next_cycle();
    inst_mem_en = 0;
    #2;
    checks++;
    if (arb_busy !== 1'b1) begin
      errors++; $display("FAIL rstwait_busy: got busy=%b expected 1", arb_busy);
    end
    #1;
    RSTN = 0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL rstwait_async: got %h expected 0", all_out);
    end
    next_cycle();
    mem_rvld = 1; mem_rdata = 32'h5555_5555;
    #2;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL rstwait_held: got %h expected 0", all_out);
    end
    next_cycle();
    RSTN = 1;
    #2;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL rstwait_stray_rvld: got %h expected 0", all_out);
    end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_lsu_write();
`ifdef ARB_ROUND_ROBIN_EN
    test_round_robin();
`else
    test_fixed_priority();
`endif
    test_delayed_rsp();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
